// File: rtl/task_source_arbiter_pkg.sv
// Shared definitions for the task source arbiter: common task width, FSM
// state encoding and the perf counter width.
package task_source_arbiter_pkg;

    localparam int TASK_W = 16;
    localparam int PERF_W = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/task_source_arbiter_if.sv
// Handshake bundle between NUM_SRC task producers, the arbiter and the load
// balancer. The master modport is the arbiter's view.
interface task_source_arbiter_if
    import task_source_arbiter_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int DATA_W   = TASK_W,
    parameter int WEIGHT_W = 4
) ();

    logic [NUM_SRC*DATA_W-1:0]   src_data;
    logic [NUM_SRC-1:0]          src_valid;
    logic [NUM_SRC-1:0]          src_ready;
    logic [NUM_SRC*WEIGHT_W-1:0] src_weight;
    logic [DATA_W-1:0]           out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [$clog2(NUM_SRC)-1:0]  out_src_id;

    modport master (
        input  src_data, src_valid, src_weight, out_ready,
        output src_ready, out_data, out_valid, out_src_id
    );

    modport slave (
        output src_data, src_valid, src_weight, out_ready,
        input  src_ready, out_data, out_valid, out_src_id
    );

endinterface

// File: rtl/task_source_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching from
// ptr+1 upwards, wrapping modulo NUM_SRC.
module task_source_arbiter_rr_pick
    import task_source_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = (int'(ptr) + k) % NUM_SRC;
            if (req[cand]) begin
                found = 1'b1;
                idx   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/task_source_arbiter.sv
// Weighted round-robin arbiter merging NUM_SRC task streams into one
// registered stream. Optional per-source beat counters: TASK_ARB_PERF_CNT_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ARB_IDLE  | no owner; pick next valid source, latch its burst weight
// ARB_GRANT | grant_id owns the output; accept up to burst_left+1 beats
module task_source_arbiter
    import task_source_arbiter_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int DATA_W   = TASK_W,
    parameter int WEIGHT_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    task_source_arbiter_if.master        bus,
`ifdef TASK_ARB_PERF_CNT_EN
    input  logic                         perf_clr,
    output logic [NUM_SRC*PERF_W-1:0]    perf_beats,
`endif
    output logic                         arb_busy
);

    localparam int ID_W = $clog2(NUM_SRC);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [WEIGHT_W-1:0] burst_left_q, burst_left_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ID_W-1:0]     out_src_id_q, out_src_id_d;
    logic                out_valid_q, out_valid_d;

    logic                can_load;
    logic                accept;
    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic [WEIGHT_W-1:0] pick_weight;
    logic [NUM_SRC-1:0]  src_ready;

    task_source_arbiter_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req   (bus.src_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign can_load    = !out_valid_q || bus.out_ready;
    assign pick_weight = bus.src_weight[int'(pick_idx)*WEIGHT_W +: WEIGHT_W];

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        burst_left_d = burst_left_q;
        src_ready    = '0;
        accept       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d      = ARB_GRANT;
                    grant_id_d   = pick_idx;
                    burst_left_d = (pick_weight == '0) ? '0 : pick_weight - 1'b1;
                end
            end
            ARB_GRANT: begin
                src_ready[grant_id_q] = can_load;
                // A dropped valid forfeits the rest of the burst.
                if (!bus.src_valid[grant_id_q]) begin
                    rr_ptr_d = grant_id_q;
                    state_d  = ARB_IDLE;
                end else if (can_load) begin
                    accept = 1'b1;
                    if (burst_left_q == '0) begin
                        rr_ptr_d = grant_id_q;
                        state_d  = ARB_IDLE;
                    end else begin
                        burst_left_d = burst_left_q - 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_id_d = out_src_id_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = bus.src_data[int'(grant_id_q)*DATA_W +: DATA_W];
            out_src_id_d = grant_id_q;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= ID_W'(NUM_SRC - 1);
            grant_id_q   <= '0;
            burst_left_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_id_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            burst_left_q <= burst_left_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_id_q <= out_src_id_d;
        end
    end

    assign bus.src_ready  = src_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src_id = out_src_id_q;
    assign arb_busy       = (state_q == ARB_GRANT) || out_valid_q;

`ifdef TASK_ARB_PERF_CNT_EN
    logic [PERF_W-1:0] perf_q [NUM_SRC];

    // Clear beats a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) perf_q[i] <= '0;
        end else if (perf_clr) begin
            for (int i = 0; i < NUM_SRC; i++) perf_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (accept && (grant_id_q == ID_W'(i)) && (perf_q[i] != '1))
                    perf_q[i] <= perf_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        perf_beats = '0;
        for (int i = 0; i < NUM_SRC; i++) perf_beats[i*PERF_W +: PERF_W] = perf_q[i];
    end
`endif

endmodule

// File: tb/tb_task_source_arbiter.sv
// Directed and randomized bench for task_source_arbiter; a beat scoreboard
// plus an arithmetic weighted round-robin order model.
module tb_task_source_arbiter;
    import task_source_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int WW   = 4;
    localparam int HUGE = 1 << 30;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic arb_busy;
`ifdef TASK_ARB_PERF_CNT_EN
    logic          perf_clr = 1'b0;
    logic [N*16-1:0] perf_beats;
    int            perf_model [N];
`endif

    task_source_arbiter_if #(.NUM_SRC(N), .DATA_W(DW), .WEIGHT_W(WW)) bus ();

    task_source_arbiter #(.NUM_SRC(N), .DATA_W(DW), .WEIGHT_W(WW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
`ifdef TASK_ARB_PERF_CNT_EN
        .perf_clr   (perf_clr),
        .perf_beats (perf_beats),
`endif
        .arb_busy   (arb_busy)
    );

    always #5 clk = ~clk;

    int         ncmp = 0;
    int         nfail = 0;
    int         sent [N];
    int         rcvd [N];
    int         lim  [N];
    int         wts  [N];
    logic [N-1:0] en;
    int         rdy_pct = 100;
    int         cyc = 0;
    int         obs_ids [$];
    int         xfer_cyc [$];

    function automatic logic [DW-1:0] word(int s, int k);
        return DW'((s << 12) | (k & 12'hFFF));
    endfunction

    // Expected source of the i-th output beat when every source stays valid.
    function automatic int exp_id(int i);
        int total = 0;
        int r;
        for (int s = 0; s < N; s++) total += (wts[s] == 0) ? 1 : wts[s];
        r = i % total;
        for (int s = 0; s < N; s++) begin
            int w = (wts[s] == 0) ? 1 : wts[s];
            if (r < w) return s;
            r -= w;
        end
        return -1;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int s = 0; s < N; s++) begin
            bus.src_valid[s]             = en[s] && (sent[s] < lim[s]);
            bus.src_data[s*DW +: DW]     = word(s, sent[s]);
            bus.src_weight[s*WW +: WW]   = WW'(wts[s]);
        end
        bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        logic         clr;
        int           id;
        @(negedge clk);
        acc = bus.src_valid & bus.src_ready;
        check("ready_onehot", 64'($countones(bus.src_ready) <= 1), 64'd1);
        if (bus.out_valid && bus.out_ready) begin
            id = int'(bus.out_src_id);
            check("beat_data", 64'(bus.out_data), 64'(word(id, rcvd[id])));
            rcvd[id]++;
            obs_ids.push_back(id);
            xfer_cyc.push_back(cyc);
        end
`ifdef TASK_ARB_PERF_CNT_EN
        clr = perf_clr;
`else
        clr = 1'b0;
`endif
        @(posedge clk);
        #1;
        cyc++;
        for (int s = 0; s < N; s++) if (acc[s]) sent[s]++;
`ifdef TASK_ARB_PERF_CNT_EN
        for (int s = 0; s < N; s++) begin
            if (clr) perf_model[s] = 0;
            else if (acc[s] && perf_model[s] < 65535) perf_model[s]++;
        end
`endif
        drive();
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_out_valid"},  64'(bus.out_valid),  64'd0);
        check({tag, "_out_data"},   64'(bus.out_data),   64'd0);
        check({tag, "_out_src_id"}, 64'(bus.out_src_id), 64'd0);
        check({tag, "_src_ready"},  64'(bus.src_ready),  64'd0);
        check({tag, "_arb_busy"},   64'(arb_busy),       64'd0);
        en = '0;
        for (int s = 0; s < N; s++) begin
            sent[s] = rcvd[s];
            lim[s]  = HUGE;
`ifdef TASK_ARB_PERF_CNT_EN
            perf_model[s] = 0;
`endif
        end
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_ids.delete();
        xfer_cyc.delete();
    endtask

    task automatic run_beats(string tag, int n, int budget);
        int c = 0;
        while (obs_ids.size() < n && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_done"}, 64'(obs_ids.size() >= n), 64'd1);
    endtask

    task automatic check_order(string tag, int n);
        for (int i = 0; i < n && i < obs_ids.size(); i++)
            check(tag, 64'(obs_ids[i]), 64'(exp_id(i)));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [DW-1:0] d0;
        logic [1:0]    id0;

        en = '0;
        for (int s = 0; s < N; s++) begin
            sent[s] = 0; rcvd[s] = 0; lim[s] = HUGE; wts[s] = 1;
`ifdef TASK_ARB_PERF_CNT_EN
            perf_model[s] = 0;
`endif
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        do_reset("por");

        // Reset while the output register holds a stalled beat.
        en = '1; rdy_pct = 0; drive();
        repeat (4) tick();
        check("stall_pre_rst_valid", 64'(bus.out_valid), 64'd1);
        do_reset("rst_stall");
        en = '1; rdy_pct = 100; drive();
        run_beats("rst_first", 1, 20);
        check("rst_first_id", 64'(obs_ids.size() > 0 ? obs_ids[0] : -1), 64'd0);

        // Plain round robin, weights 1.
        do_reset("rr");
        en = '1; rdy_pct = 100; drive();
        run_beats("rr", 8, 100);
        check_order("rr_order", 8);
        for (int i = 1; i < 8 && i < xfer_cyc.size(); i++)
            check("rr_spacing", 64'(xfer_cyc[i] - xfer_cyc[i-1]), 64'd2);

        // Weighted bursts {3,1,0,2}.
        do_reset("wgt");
        wts[0] = 3; wts[1] = 1; wts[2] = 0; wts[3] = 2;
        en = '1; rdy_pct = 100; drive();
        run_beats("wgt", 14, 200);
        check_order("wgt_order", 14);

        // Five-cycle backpressure.
        do_reset("stall");
        for (int s = 0; s < N; s++) wts[s] = 1;
        en = '1; rdy_pct = 100; drive();
        run_beats("stall_pre", 3, 100);
        rdy_pct = 0; drive();
        c = 0;
        while (!bus.out_valid && c < 6) begin tick(); c++; end
        check("stall_ov", 64'(bus.out_valid), 64'd1);
        d0 = bus.out_data; id0 = bus.out_src_id;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            check("stall_data", 64'(bus.out_data), 64'(d0));
            check("stall_id",   64'(bus.out_src_id), 64'(id0));
            check("stall_ready", 64'(bus.src_ready), 64'd0);
        end
        rdy_pct = 100; drive();
        run_beats("stall_post", 10, 200);
        check_order("stall_order", 10);

        // Early release of source 1 after two of its four beats.
        do_reset("early");
        wts[0] = 1; wts[1] = 4; wts[2] = 1; wts[3] = 1;
        en = 4'b0110; lim[1] = sent[1] + 2; rdy_pct = 100; drive();
        run_beats("early", 3, 100);
        if (obs_ids.size() >= 3) begin
            check("early_id0", 64'(obs_ids[0]), 64'd1);
            check("early_id1", 64'(obs_ids[1]), 64'd1);
            check("early_id2", 64'(obs_ids[2]), 64'd2);
            check("early_gap", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd3);
        end

        // Randomized weights and backpressure.
        for (int p = 0; p < 4; p++) begin
            do_reset("rnd");
            for (int s = 0; s < N; s++) wts[s] = int'($urandom_range(0, 15));
            en = '1; rdy_pct = int'($urandom_range(40, 90)); drive();
            run_beats("rnd", 40, 4000);
            check_order("rnd_order", 40);
        end
        for (int s = 0; s < N; s++)
            check("conserve", 64'((sent[s] - rcvd[s] >= 0) && (sent[s] - rcvd[s] <= 1)), 64'd1);

`ifdef TASK_ARB_PERF_CNT_EN
        do_reset("perf");
        wts[0] = 15; en = 4'b0001; rdy_pct = 100; drive();
        run_beats("perf_sat", 66000, 80000);
        check("perf_sat", 64'(perf_beats[15:0]), 64'hFFFF);
        check("perf_model", 64'(perf_beats[15:0]), 64'(perf_model[0]));
        c = 0;
        while (!bus.src_ready[0] && c < 20) begin tick(); c++; end
        check("perf_clr_ready", 64'(bus.src_ready[0]), 64'd1);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        check("perf_clr", 64'(perf_beats[15:0]), 64'd0);
        check("perf_clr_model", 64'(perf_beats[15:0]), 64'(perf_model[0]));
        en = '0; drive();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/task_source_arbiter.md
Name: task_source_arbiter

Overview:
- Weighted round-robin arbiter that shares the single task input of the PE load balancer between NUM_SRC task producers, such as the host command queue, DMA completion and the layer sequencer.
- Merges the request streams into one valid/ready task stream through a registered output stage.
- Tags each output beat with the ID of the source that sent it.
- Sits directly upstream of the load balancer's task_data/task_valid/task_ready port.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DATA_W, 16, task word width; matches the load balancer task width.
- WEIGHT_W, 4, width of each per-source burst weight.

Ports:
- clk  input  1  system clock; every flop is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- src_data  input  NUM_SRC*DATA_W  task words; source i occupies bits [i*DATA_W +: DATA_W].
- src_valid  input  NUM_SRC  per-source request valid.
- src_ready  output  NUM_SRC  per-source accept. Combinational. At most one bit is high.
- src_weight  input  NUM_SRC*WEIGHT_W  beats per grant; a value of 0 is treated as 1.
- out_data  output  DATA_W  registered task word to the load balancer.
- out_valid  output  1  registered valid.
- out_ready  input  1  load balancer ready.
- out_src_id  output  $clog2(NUM_SRC)  source ID of the current out_data.
- arb_busy  output  1  high while state is GRANT or out_valid is high.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_src_id=0, src_ready=0, arb_busy=0.
- Reset internals: state=IDLE, rr_ptr=NUM_SRC-1 (so source 0 wins first), grant_id=0, burst_left=0.
- Reset mid-operation: any beat held in the output register is dropped; sources must re-present it.
- Output stage: can_load = !out_valid || out_ready.
  - A beat transfers out when out_valid && out_ready.
  - out_data and out_src_id are held stable while out_valid && !out_ready.
- FSM states: IDLE and GRANT.
- IDLE:
  - src_ready is all 0.
  - If any src_valid is set, pick the first valid source, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC.
  - Latch grant_id = picked source.
  - Latch burst_left = max(src_weight[picked],1) - 1. The weight is sampled only at this point; a weight change mid-burst takes effect at the next grant.
  - Next state is GRANT.
  - If no source is valid, stay in IDLE.
- GRANT:
  - src_ready[grant_id] = can_load.
  - On an accept (src_valid && src_ready): out_data <= src_data[grant_id], out_src_id <= grant_id, out_valid <= 1.
  - Accept with burst_left==0: rr_ptr <= grant_id, go to IDLE.
  - Accept with burst_left>0: decrement burst_left, stay in GRANT.
  - src_valid[grant_id]==0 in any GRANT cycle (early release): rr_ptr <= grant_id, go to IDLE. The unused burst is forfeited.
  - A source that has not yet been accepted may not drop src_valid without losing its grant; it does not lose data.
- out_valid clears on a transfer out unless a new beat is loaded in the same cycle (simultaneous load and unload is allowed).
- Latency: 1 cycle from accept to out_valid.
- Re-arbitration: there is one IDLE bubble cycle between grants. A weight of w gives w beats per w+1 cycles when the downstream never stalls.
- Fairness: rr_ptr always advances past the last owner, so with all sources valid the order is 0,1,...,NUM_SRC-1,0. No source starves.

Optional Feature:
- Macro: TASK_ARB_PERF_CNT_EN.
- When defined: adds output perf_beats [NUM_SRC*16]. It holds one 16-bit saturating counter per source.
  - The counter increments on each accept from that source and holds at 16'hFFFF.
  - Counters reset to 0 on rst_n.
  - Input perf_clr (1 bit) synchronously zeroes all counters; perf_clr has priority over an increment in the same cycle.
- When undefined: neither port exists and no counter logic is present.

Decomposition:
- Shared npu package (npu_definitions.vh):
  - TASK_W=16, the common task width used here and in the load balancer.
  - The state encodings ARB_IDLE=1'b0 and ARB_GRANT=1'b1.
- One natural sub-module, rr_pick: a purely combinational round-robin picker.
  - Inputs: req[NUM_SRC] and ptr.
  - Outputs: found and idx.
  - It is reusable by other schedulers.

Test Plan:
- Reset during a stall: assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 and src_ready=0 immediately; after release, source 0 is picked first.
- Round-robin order: all 4 sources valid, weights 1, out_ready=1 -> out_src_id sequence 0,1,2,3,0,... with a beat every 2nd cycle.
- Weighted bursts: weights {3,1,0,2}, all valid -> out_src_id sequence 0,0,0,1,2,3,3, repeating (weight 0 gives 1 beat).
- Early release and backpressure:
  - Source 1 (weight 4) drops valid after 2 beats -> grant moves to source 2 after one IDLE cycle.
  - out_ready=0 for 5 cycles -> out_data/out_src_id stay stable, src_ready=0, and no beat is lost or duplicated (scoreboard against the source streams).
- Perf counters (TASK_ARB_PERF_CNT_EN):
  - 70000 beats from source 0 -> perf_beats[15:0]=16'hFFFF (saturated).
  - perf_clr pulsed alongside an accept -> counter reads 0.
